irq_ctrl: RTL

- Parametrised vectored interrupt controller that replaces the fixed four-line interrupt scheme between the peripherals and the CPU control unit.
- Supports NUM_IRQ sources, selectable per channel as edge- or level-triggered.
- Provides enable and pending registers through an I/O-mapped register window, fixed priority (lowest index wins) and optional nested preemption.
- Returns vectors through a req/ack/done handshake and issues per-channel clear pulses to the sources.

---
 rtl/irq_ctrl_pkg.sv | 30 +++
 rtl/irq_ctrl_prio_enc.sv | 24 ++
 rtl/irq_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: register
// offsets, FSM state encodings and a small byte-select helper.
package irq_ctrl_pkg;

    // I/O register window offsets
    localparam logic [2:0] REG_EN_LO    = 3'd0;
    localparam logic [2:0] REG_EN_HI    = 3'd1;
    localparam logic [2:0] REG_PEND_LO  = 3'd2;
    localparam logic [2:0] REG_PEND_HI  = 3'd3;
    localparam logic [2:0] REG_INSVC_LO = 3'd4;
    localparam logic [2:0] REG_INSVC_HI = 3'd5;
    localparam logic [2:0] REG_STATUS   = 3'd6;
    localparam logic [2:0] REG_RSVD     = 3'd7;

    // Channel ids are always carried in 4 bits (up to 16 channels)
    localparam int IRQ_ID_W = 4;

    // Request FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ACKED = 2'd2
    } irq_state_e;

    // Picks the low or high byte of a 16-bit zero-padded register image
    function automatic logic [7:0] byte_sel(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set
// bit of vec and a valid flag when any bit is set.
module prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: per-channel edge/level capture, enable
// and pending registers behind an 8-bit I/O window, fixed priority
// (lowest index wins) with optional nesting, and a req/ack/done
// handshake toward the CPU with per-channel clear pulses to the sources.
//
// Handshake: irq_req is held with irq_vector frozen until the CPU pulses
// irq_ack (transfer happens on the cycle irq_ack=1 while irq_req=1) or
// global_en falls (request withdrawn, pending kept). irq_done retires the
// highest-priority in-service channel at any time.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                NUM_IRQ       = 8,
    parameter int                ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(16'h0008),
    parameter int                VECTOR_STRIDE = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK    = {NUM_IRQ{1'b1}},
    parameter bit                NEST          = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] irq_clr,
    input  logic               global_en,
    output logic               irq_req,
    output logic [ADDR_W-1:0]  irq_vector,
    input  logic               irq_ack,
    input  logic               irq_done,
    input  logic [2:0]         io_addr,
    input  logic [7:0]         io_wdata,
    input  logic               io_we,
    input  logic               io_re,
    output logic [7:0]         io_rdata,
    output logic [1:0]         dbg_state
);

    irq_state_e           state_q, state_d;
    logic [NUM_IRQ-1:0]   en_q, en_d;
    logic [NUM_IRQ-1:0]   pend_q, pend_d;
    logic [NUM_IRQ-1:0]   isvc_q, isvc_d;
    logic [NUM_IRQ-1:0]   clr_q, clr_d;
    logic [NUM_IRQ-1:0]   prev_q;
    logic                 req_q, req_d;
    logic [ADDR_W-1:0]    vec_q, vec_d;
    logic [IRQ_ID_W-1:0]  id_q, id_d;
    logic [7:0]           rdata_q, rdata_d;

    logic [NUM_IRQ-1:0]   trig;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   ack_mask;
    logic [NUM_IRQ-1:0]   done_mask;
    logic [IRQ_ID_W-1:0]  win_idx, isvc_idx;
    logic                 win_valid, isvc_valid;
    logic                 allowed;
    logic [15:0]          en_w, w1c_w;
    logic [15:0]          en16, pend16, isvc16;

    // Edge channels fire on a rising transition, level channels while high
    assign trig     = (EDGE_MASK & irq_in & ~prev_q) | (~EDGE_MASK & irq_in);
    assign eligible = pend_q & en_q;

    prio_enc #(.N(NUM_IRQ), .IDX_W(IRQ_ID_W)) u_win_enc (
        .vec   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    prio_enc #(.N(NUM_IRQ), .IDX_W(IRQ_ID_W)) u_isvc_enc (
        .vec   (isvc_q),
        .idx   (isvc_idx),
        .valid (isvc_valid)
    );

    // A winner may be presented only if it outranks everything in service
    always_comb begin
        if (NEST) begin
            allowed = win_valid && (!isvc_valid || (win_idx < isvc_idx));
        end else begin
            allowed = win_valid && !isvc_valid;
        end
    end

    // irq_done retires the lowest-index in-service channel (pre-ack view)
    always_comb begin
        done_mask = '0;
        if (irq_done && isvc_valid) begin
            done_mask = NUM_IRQ'(1) << isvc_idx;
        end
    end

    // Request FSM: next state, frozen id/vector and the ack strobe
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        vec_d    = vec_q;
        id_d     = id_q;
        ack_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (global_en && allowed) begin
                    id_d    = win_idx;
                    vec_d   = VECTOR_BASE + ADDR_W'(win_idx) * ADDR_W'(VECTOR_STRIDE);
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    ack_mask = NUM_IRQ'(1) << id_q;
                    req_d    = 1'b0;
                    state_d  = ST_ACKED;
                end else if (!global_en) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACKED: begin
                // one settle cycle so the acked channel cannot re-win
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Enable writes, pending set/clear (set wins), in-service update
    always_comb begin
        en_w  = 16'(en_q);
        w1c_w = '0;
        if (io_we) begin
            case (io_addr)
                REG_EN_LO:   en_w[7:0]   = io_wdata;
                REG_EN_HI:   en_w[15:8]  = io_wdata;
                REG_PEND_LO: w1c_w[7:0]  = io_wdata;
                REG_PEND_HI: w1c_w[15:8] = io_wdata;
                default: ;
            endcase
        end
        en_d   = en_w[NUM_IRQ-1:0];
        pend_d = (pend_q & ~(w1c_w[NUM_IRQ-1:0] | ack_mask)) | trig;
        isvc_d = (isvc_q & ~done_mask) | ack_mask;
        clr_d  = ack_mask;
    end

    // Register read mux; data appears the cycle after io_re
    always_comb begin
        en16    = 16'(en_q);
        pend16  = 16'(pend_q);
        isvc16  = 16'(isvc_q);
        rdata_d = rdata_q;
        if (io_re) begin
            case (io_addr)
                REG_EN_LO:    rdata_d = byte_sel(en16, 1'b0);
                REG_EN_HI:    rdata_d = byte_sel(en16, 1'b1);
                REG_PEND_LO:  rdata_d = byte_sel(pend16, 1'b0);
                REG_PEND_HI:  rdata_d = byte_sel(pend16, 1'b1);
                REG_INSVC_LO: rdata_d = byte_sel(isvc16, 1'b0);
                REG_INSVC_HI: rdata_d = byte_sel(isvc16, 1'b1);
                REG_STATUS:   rdata_d = {req_q, 3'b000, id_q};
                default:      rdata_d = 8'h00;
            endcase
        end
    end

    // State registers; prev_q tracks irq_in even in reset so a held line
    // does not look like an edge when reset is released
    always_ff @(posedge clk) begin
        prev_q <= irq_in;
        if (reset) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            pend_q  <= '0;
            isvc_q  <= '0;
            clr_q   <= '0;
            req_q   <= 1'b0;
            vec_q   <= VECTOR_BASE;
            id_q    <= '0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            isvc_q  <= isvc_d;
            clr_q   <= clr_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
        end
    end

    assign irq_clr    = clr_q;
    assign irq_req    = req_q;
    assign irq_vector = vec_q;
    assign io_rdata   = rdata_q;
    assign dbg_state  = state_q;

endmodule
